// File: rtl/wb_core_master.sv
// Wishbone classic single-transfer master: turns one valid/ready core request into one
// Wishbone cycle and returns read data, or a timeout error, on a valid/ready response channel.
module wb_core_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_we_o,
  output logic                  wb_stb_o,
  output logic                  wb_cyc_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  // A zero timeout still needs a one-bit counter so the declaration stays legal.
  localparam int CW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = LAST_INT[CW-1:0];
  localparam logic [CW-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          timeout_hit;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    timeout_hit = 1'b0;
    if (TIMEOUT_CYCLES != 0) timeout_hit = (cnt == CNT_LAST);
  end

  // Ready is gated by reset so no request is taken while the bridge is held in reset.
  assign req_ready_o = (state == S_IDLE) && !rst;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_cyc_o    <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            wb_adr_o <= req_addr_i;
            wb_dat_o <= req_wdata_i;
            wb_we_o  <= req_we_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            cnt      <= '0;
            state    <= S_BUS;
          end
        end

        S_BUS: begin
          if (wb_ack_i) begin
            // Ack takes priority over a timeout landing in the same cycle.
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            rsp_rdata_o <= wb_we_o ? '0 : wb_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
          end else if (timeout_hit) begin
            wb_stb_o    <= 1'b0;
            wb_cyc_o    <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b1;
            rsp_valid_o <= 1'b1;
            state       <= S_RESP;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: begin
          wb_stb_o    <= 1'b0;
          wb_cyc_o    <= 1'b0;
          rsp_valid_o <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_core_master.sv
// Randomised bench for wb_core_master: a scripted Wishbone slave plus an arithmetic
// model of the expected response (bus length, error flag, read data) per transaction.
module tb_wb_core_master;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_we, wb_stb, wb_cyc, wb_ack;

  int checks   = 0;
  int failures = 0;

  wb_core_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_we_o(wb_we),
    .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cyc"}, wb_cyc, 0);
    check({tag, "_stb"}, wb_stb, 0);
    check({tag, "_we"}, wb_we, 0);
    check({tag, "_adr"}, wb_adr, 0);
    check({tag, "_dat"}, wb_dat_o, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
  endtask

  // One complete transaction. ack_delay = BUS cycle index (0 = first) in which the
  // slave acks; a value >= TO means the slave never acks before the timeout.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [DW-1:0] slave_data, input int ack_delay, input int rsp_wait);
    int            guard;
    int            bus_cycles;
    int            exp_cycles;
    logic          exp_err;
    logic [DW-1:0] exp_rdata;

    guard = 0;
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    check("req_ready_idle", req_ready, 1);

    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
    check("accept_cyc", wb_cyc, 1);
    check("accept_stb", wb_stb, 1);
    check("accept_adr", wb_adr, addr);
    check("accept_we", wb_we, we);
    check("accept_dat", wb_dat_o, wdata);
    check("busy_not_ready", req_ready, 0);

    bus_cycles = 0;
    while (wb_cyc && bus_cycles < 100) begin
      if (bus_cycles == ack_delay) begin
        wb_ack = 1'b1; wb_dat_i = slave_data;
      end else begin
        wb_ack = 1'b0; wb_dat_i = $urandom;
      end
      step();
      wb_ack = 1'b0;
      bus_cycles++;
      if (wb_cyc) begin
        check("hold_adr", wb_adr, addr);
        check("hold_dat", wb_dat_o, wdata);
        check("hold_we", wb_we, we);
        check("hold_rsp_idle", rsp_valid, 0);
      end
    end

    if (TO == 0 || ack_delay < TO) begin
      exp_cycles = ack_delay + 1;
      exp_err    = 1'b0;
      exp_rdata  = we ? '0 : slave_data;
    end else begin
      exp_cycles = TO;
      exp_err    = 1'b1;
      exp_rdata  = '0;
    end
    check("bus_cycles", bus_cycles, exp_cycles);
    check("end_stb", wb_stb, 0);
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_rdata", rsp_rdata, exp_rdata);

    // A pending request is presented throughout the response wait.
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < rsp_wait; i++) begin
      step();
      check("bp_valid", rsp_valid, 1);
      check("bp_err", rsp_err, exp_err);
      check("bp_rdata", rsp_rdata, exp_rdata);
      check("bp_not_ready", req_ready, 0);
      check("bp_no_cyc", wb_cyc, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_done", rsp_valid, 0);
    check("no_same_cycle_accept", wb_cyc, 0);
    check("ready_after_resp", req_ready, 1);
    req_valid = 1'b0;
  endtask

  task automatic reset_mid_bus();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h155; req_wdata = 32'h0;
    step();
    req_valid = 1'b0;
    step();
    check("pre_reset_stb", wb_stb, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    check("reset_not_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    wb_ack = 1'b1; wb_dat_i = 32'hBAD0BAD0;
    step();
    wb_ack = 1'b0;
    step();
    check("spurious_ack_rsp", rsp_valid, 0);
    check("spurious_ack_cyc", wb_cyc, 0);
    check("post_reset_ready", req_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; wb_ack = 1'b0; wb_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_out_of_reset", req_ready, 1);

    run_txn(1'b0, 10'h004, 32'h0, 32'hDEADBEEF, 1, 0);
    run_txn(1'b1, 10'h3FF, 32'hA5A5A5A5, 32'h11111111, 1, 0);
    run_txn(1'b0, 10'h020, 32'h0, 32'h22222222, 1000, 0);
    run_txn(1'b1, 10'h0F0, 32'h5A5A5A5A, 32'h0, 1000, 2);
    run_txn(1'b0, 10'h100, 32'h0, 32'h33333333, 2, 5);
    reset_mid_bus();
    run_txn(1'b0, 10'h200, 32'h0, 32'h12345678, TO - 1, 0);
    for (int i = 0; i < 4; i++)
      run_txn(1'b0, AW'(i * 3), 32'h0, 32'hC0DE0000 + i, 1, 0);

    // Idle-time ack must be ignored.
    wb_ack = 1'b1; wb_dat_i = 32'hFFFFFFFF;
    step();
    wb_ack = 1'b0;
    check("idle_ack_rsp", rsp_valid, 0);
    check("idle_ack_cyc", wb_cyc, 0);

    for (int n = 0; n < 40; n++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, TO + 4));
      run_txn(1'($urandom), AW'($urandom), $urandom, $urandom, d, int'($urandom_range(0, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
